// File: rtl/shift_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// shift_ctrl_pkg
// Shared types and constants for the shift-register sequencer.
//   state_t    : sequencer states (IDLE, LOAD, SHIFT, DONE)
//   MODE_FILL  : refill the register with a constant bit while shifting
//   MODE_ROT   : feed the outgoing LSB back into the MSB (rotate)
//   serial_in(): selects the register serial input for a given mode
// -----------------------------------------------------------------------------
package shift_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic MODE_FILL = 1'b0;
  localparam logic MODE_ROT  = 1'b1;

  // In rotate mode the bit leaving at the LSB re-enters at the MSB, so after
  // WIDTH shifts the register is back to the word that was loaded.
  function automatic logic serial_in(input logic mode_sel,
                                     input logic fill_val,
                                     input logic lsb);
    return (mode_sel == MODE_ROT) ? lsb : fill_val;
  endfunction

endpackage

// File: rtl/shift_bit_counter.sv
// -----------------------------------------------------------------------------
// shift_bit_counter
// Counts shift cycles of one word. Saturates at WIDTH-1 so it can never wrap
// back to zero while the sequencer is still shifting.
// Ports:
//   CLK  in  clock (posedge)
//   RST  in  asynchronous active-high reset, count -> 0
//   clr  in  synchronous clear (priority over en)
//   en   in  count enable
//   tc   out terminal count, high while count == WIDTH-1
// -----------------------------------------------------------------------------
module shift_bit_counter
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (en && (count_reg != LAST)) begin
      count_next = count_reg + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign tc = (count_reg == LAST);

endmodule

// File: rtl/shift_register_right.sv
// -----------------------------------------------------------------------------
// shift_register_right
// WIDTH-bit negedge-clocked register with parallel load, shift-right and an
// asynchronous active-low clear. This is the datapath the controller drives.
// Ports:
//   CLK      in  clock (register updates on negedge)
//   Clear_n  in  asynchronous clear, active low, D -> 0
//   LD       in  parallel load of InP (priority over SHFT)
//   SHFT     in  shift right, InS enters at the MSB
//   InP      in  parallel input word
//   InS      in  serial input
//   D        out register contents
// -----------------------------------------------------------------------------
module shift_register_right #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             Clear_n,
  input  logic             LD,
  input  logic             SHFT,
  input  logic [WIDTH-1:0] InP,
  input  logic             InS,
  output logic [WIDTH-1:0] D
);

  logic [WIDTH-1:0] shifted;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (gi == WIDTH - 1) begin : g_msb
        assign shifted[gi] = InS;
      end else begin : g_low
        assign shifted[gi] = D[gi+1];
      end
    end
  endgenerate

  always_ff @(negedge CLK or negedge Clear_n) begin
    if (!Clear_n) begin
      D <= '0;
    end else if (LD) begin
      D <= InP;
    end else if (SHFT) begin
      D <= shifted;
    end
  end

endmodule

// File: rtl/shift_register_controller.sv
// -----------------------------------------------------------------------------
// shift_register_controller
// Sequencer for a negedge shift-right register. Accepts a word over a
// valid/ready handshake, issues one LD cycle and then exactly WIDTH SHFT
// cycles, presenting the bits that fall out of the register LSB-first on a
// registered serial output. Everything here runs on posedge CLK so the
// register strobes are stable before each register negedge.
// Ports:
//   CLK, RST   clock / asynchronous active-high reset
//   in_valid   word offered            in_ready  word can be taken (IDLE)
//   in_data    word to serialize       mode      0 fill, 1 rotate (at accept)
//   fill_bit   fill value (at accept)  clr_req   abort + register clear
//   reg_q      register D feedback
//   LD, SHFT   register strobes        Clear_n   register clear, active low
//   InP, InS   register inputs         ser_out   serial bit, ser_valid qualifier
//   busy       state != IDLE           done      one-cycle end-of-word pulse
// -----------------------------------------------------------------------------
module shift_register_controller
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             mode,
  input  logic             fill_bit,
  input  logic             clr_req,
  input  logic [WIDTH-1:0] reg_q,
  output logic             LD,
  output logic             SHFT,
  output logic             Clear_n,
  output logic [WIDTH-1:0] InP,
  output logic             InS,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  state_t           state_reg;
  state_t           state_next;
  logic             accept;
  logic             tc;

  logic [WIDTH-1:0] inp_reg;
  logic             mode_reg;
  logic             fill_reg;
  logic             ser_out_reg;
  logic             ser_valid_reg;
  logic             clear_n_reg;

  // Only the LSB of the register is observed here; the upper bits matter
  // to the register itself, not to the sequencer.
  logic             reg_q_unused;
  assign reg_q_unused = ^reg_q[WIDTH-1:1];

  // An abort request on the same edge as an offered word takes priority,
  // so the word is left with the source.
  assign accept = (state_reg == IDLE) && in_valid && !clr_req;

  // ---------------------------------------------------------------------------
  // Bit counter: runs only in SHIFT, cleared everywhere else so it always
  // starts a word at zero.
  // ---------------------------------------------------------------------------
  shift_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .CLK (CLK),
    .RST (RST),
    .clr (clr_req || (state_reg != SHIFT)),
    .en  (state_reg == SHIFT),
    .tc  (tc)
  );

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and state-decoded strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    LD         = 1'b0;
    SHFT       = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;

    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (accept) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        LD         = 1'b1;
        state_next = SHIFT;
      end
      SHIFT: begin
        SHFT = 1'b1;
        if (tc) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (clr_req) begin
      state_next = IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // Capture registers and serial output
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      inp_reg       <= '0;
      mode_reg      <= MODE_FILL;
      fill_reg      <= 1'b0;
      ser_out_reg   <= 1'b0;
      ser_valid_reg <= 1'b0;
      clear_n_reg   <= 1'b0;
    end else begin
      // Clear_n is low for exactly the cycle after a clr_req edge, and
      // comes out of reset on the first edge after RST falls.
      clear_n_reg <= !clr_req;

      if (accept) begin
        inp_reg  <= in_data;
        mode_reg <= mode;
        fill_reg <= fill_bit;
      end

      if (clr_req) begin
        ser_valid_reg <= 1'b0;
      end else if (state_reg == LOAD) begin
        // The register loaded at the LOAD negedge, so its LSB is bit 0.
        ser_out_reg   <= reg_q[0];
        ser_valid_reg <= 1'b1;
      end else if (state_reg == SHIFT) begin
        if (tc) begin
          // Bit WIDTH-1 has been presented; what now sits at the LSB is
          // refill/rotate data, not part of the word.
          ser_valid_reg <= 1'b0;
        end else begin
          ser_out_reg <= reg_q[0];
        end
      end
    end
  end

  assign InP       = inp_reg;
  assign InS       = serial_in(mode_reg, fill_reg, reg_q[0]);
  assign ser_out   = ser_out_reg;
  assign ser_valid = ser_valid_reg;
  assign Clear_n   = clear_n_reg;

endmodule

// File: tb/tb_shift_register_controller.sv
// -----------------------------------------------------------------------------
// tb_shift_register_controller
// Drives the controller together with shift_register_right and compares the
// serial stream, timing and register contents against a word-level model:
// every accepted word must come out as its bits LSB-first, done must follow
// the accept edge by WIDTH+1 edges, and the register must end up holding the
// word (rotate) or a wall of fill bits (fill).
// -----------------------------------------------------------------------------
module tb_shift_register_controller;

  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             mode = 1'b0;
  logic             fill_bit = 1'b0;
  logic             clr_req = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] reg_q;
  logic             LD, SHFT, Clear_n, InS, ser_out, ser_valid, busy, done;
  logic [WIDTH-1:0] InP;

  int passed = 0;
  int total  = 0;
  int fails  = 0;
  int cyc    = 0;
  int sv_cnt = 0;
  int done_cnt = 0;
  int done_cyc = -1;

  // Bits still expected on the serial output, oldest first.
  bit exp_q[$];

  always #5 CLK = ~CLK;

  shift_register_controller #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .mode      (mode),
    .fill_bit  (fill_bit),
    .clr_req   (clr_req),
    .reg_q     (reg_q),
    .LD        (LD),
    .SHFT      (SHFT),
    .Clear_n   (Clear_n),
    .InP       (InP),
    .InS       (InS),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .busy      (busy),
    .done      (done)
  );

  shift_register_right #(
    .WIDTH (WIDTH)
  ) u_reg (
    .CLK     (CLK),
    .Clear_n (Clear_n),
    .LD      (LD),
    .SHFT    (SHFT),
    .InP     (InP),
    .InS     (InS),
    .D       (reg_q)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: advance past the edge, then run the per-cycle protocol checks.
  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
    chk("ld_shft_exclusive", LD & SHFT, 1'b0);
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (ser_valid) begin
      sv_cnt++;
      chk("ser_expected", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) chk("ser_out", ser_out, exp_q.pop_front());
    end
  endtask

  // Offer a word, wait (bounded) for acceptance, follow it to IDLE.
  // After the accept edge the source presents nv/nd/nm/nf, which lets a
  // caller hold the next word while this one is in flight.
  task automatic send_word(input logic [WIDTH-1:0] d, input logic m, input logic f,
                           input logic nv, input logic [WIDTH-1:0] nd,
                           input logic nm, input logic nf, output int acc);
    int waited;
    int sv0;
    int dn0;
    logic [WIDTH-1:0] exp_d;
    in_data  = d;
    mode     = m;
    fill_bit = f;
    in_valid = 1'b1;
    waited = 0;
    while (!in_ready && waited < 32) begin
      tick();
      waited++;
    end
    chk("accept_wait", waited < 32, 1'b1);
    for (int i = 0; i < WIDTH; i++) exp_q.push_back(d[i]);
    sv0 = sv_cnt;
    dn0 = done_cnt;
    tick();
    acc = cyc;
    in_valid = nv;
    in_data  = nd;
    mode     = nm;
    fill_bit = nf;
    chk("load_ld", LD, 1'b1);
    chk("load_inp", InP, d);
    chk("load_busy", busy, 1'b1);
    chk("load_ready", in_ready, 1'b0);
    for (int k = 0; k < WIDTH + 1; k++) tick();
    // Accept edge plus WIDTH+1 further edges = WIDTH+2 edges to done.
    chk("done_pulses", done_cnt - dn0, 1);
    chk("done_latency", done_cyc - acc, WIDTH + 1);
    chk("ser_count", sv_cnt - sv0, WIDTH);
    chk("ser_drained", exp_q.size(), 0);
    exp_q.delete();
    exp_d = (m == 1'b1) ? d : {WIDTH{f}};
    chk("reg_final", reg_q, exp_d);
    chk("inp_held", InP, d);
    tick();
    chk("idle_ready", in_ready, 1'b1);
    chk("idle_busy", busy, 1'b0);
    chk("idle_done", done, 1'b0);
    $display("word data=%b mode=%0d fill=%0d accept_cyc=%0d reg=%b", d, m, f, acc, reg_q);
  endtask

  initial begin
    int acc_a;
    int acc_b;
    int sv0;
    int dn0;
    logic [WIDTH-1:0] rd;
    logic rm, rf;

    // ---------------- reset ----------------
    #2 RST = 1'b1;
    tick();
    tick();
    chk("rst_ld", LD, 1'b0);
    chk("rst_shft", SHFT, 1'b0);
    chk("rst_ser_out", ser_out, 1'b0);
    chk("rst_ser_valid", ser_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_clear_n", Clear_n, 1'b0);
    chk("rst_inp", InP, 4'b0000);
    chk("rst_reg", reg_q, 4'b0000);
    RST = 1'b0;
    chk("rel_ready", in_ready, 1'b1);
    chk("rel_clear_n_low", Clear_n, 1'b0);
    tick();
    chk("rel_clear_n_high", Clear_n, 1'b1);
    $display("reset released at cyc=%0d", cyc);

    // ---------------- directed fill and rotate ----------------
    send_word(4'b1011, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, acc_a);
    send_word(4'b0110, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, acc_a);
    send_word(4'b0100, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, acc_a);

    // ---------------- abort in the second SHIFT cycle ----------------
    in_data = 4'b1011; mode = 1'b1; fill_bit = 1'b0; in_valid = 1'b1;
    chk("abort_ready", in_ready, 1'b1);
    for (int i = 0; i < WIDTH; i++) exp_q.push_back(in_data[i]);
    sv0 = sv_cnt;
    dn0 = done_cnt;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    chk("abort_clear_n", Clear_n, 1'b0);
    chk("abort_ld", LD, 1'b0);
    chk("abort_shft", SHFT, 1'b0);
    chk("abort_ser_valid", ser_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_ready2", in_ready, 1'b1);
    chk("abort_reg", reg_q, 4'b0000);
    tick();
    chk("abort_clear_n_back", Clear_n, 1'b1);
    tick();
    chk("abort_no_done", done_cnt - dn0, 0);
    chk("abort_ser_count", sv_cnt - sv0, 2);
    exp_q.delete();
    $display("abort at cyc=%0d", cyc);

    // ---------------- clr_req vs in_valid in IDLE ----------------
    dn0 = done_cnt;
    in_data = 4'b1111; mode = 1'b0; fill_bit = 1'b1; in_valid = 1'b1; clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    in_valid = 1'b0;
    chk("cont_busy", busy, 1'b0);
    chk("cont_ld", LD, 1'b0);
    chk("cont_clear_n", Clear_n, 1'b0);
    chk("cont_inp", InP, 4'b1011);
    tick();
    chk("cont_clear_n_back", Clear_n, 1'b1);
    chk("cont_idle", busy, 1'b0);
    chk("cont_no_done", done_cnt - dn0, 0);
    $display("contention at cyc=%0d", cyc);

    // ---------------- held in_valid while busy -> back-to-back ----------------
    send_word(4'b1001, 1'b1, 1'b0, 1'b1, 4'b0011, 1'b0, 1'b1, acc_a);
    send_word(4'b0011, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, acc_b);
    chk("throughput", acc_b - acc_a, WIDTH + 3);

    // ---------------- reset in the middle of SHIFT ----------------
    in_data = 4'b1101; mode = 1'b1; fill_bit = 1'b0; in_valid = 1'b1;
    chk("midrst_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < WIDTH; i++) exp_q.push_back(in_data[i]);
    tick();
    tick();
    RST = 1'b1;
    #1;
    exp_q.delete();
    chk("midrst_ld", LD, 1'b0);
    chk("midrst_shft", SHFT, 1'b0);
    chk("midrst_ser_out", ser_out, 1'b0);
    chk("midrst_ser_valid", ser_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_clear_n", Clear_n, 1'b0);
    chk("midrst_inp", InP, 4'b0000);
    chk("midrst_reg", reg_q, 4'b0000);
    tick();
    RST = 1'b0;
    chk("midrst_rel_ready", in_ready, 1'b1);
    chk("midrst_rel_clear_n", Clear_n, 1'b0);
    tick();
    chk("midrst_clear_n_back", Clear_n, 1'b1);
    $display("mid-shift reset at cyc=%0d", cyc);

    // ---------------- randomized words ----------------
    for (int n = 0; n < 20; n++) begin
      rd = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      rm = 1'($urandom_range(0, 1));
      rf = 1'($urandom_range(0, 1));
      send_word(rd, rm, rf, 1'b0, 4'b0000, 1'b0, 1'b0, acc_a);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
